// File: rtl/face_box_sender.sv
// face_box_sender
//   Turns locally detected face boxes into a UDP payload for the host.
//   A send request snapshots BOX_NUM box coordinate sets and pulses trig
//   towards udp_packet. udp_packet then pulls payload bytes one at a time
//   with tx_read_en. Each byte is returned with one cycle of read latency.
//
//   Payload: MAGIC, seq, then six bytes per box (MSB first) of the
//   48-bit word {pad, sx, sy, ex, ey}. Box 0 occupies the LSBs of the
//   flat coordinate inputs.
//
//   Optional build macro FACE_BOX_SENDER_CHKSUM_EN appends one trailing
//   byte. That byte is the XOR of all preceding payload bytes.
//
// Ports
//   clk          rgmii_clk
//   rstn         asynchronous active-low reset
//   send         single-cycle send request
//   start_xs     box start x, BOX_NUM x XW bits
//   start_ys     box start y, BOX_NUM x YW bits
//   end_xs       box end x,   BOX_NUM x XW bits
//   end_ys       box end y,   BOX_NUM x YW bits
//   trig         one-cycle pulse to udp_packet
//   tx_read_en   byte request from udp_packet
//   tx_data      payload byte, valid the cycle after tx_read_en
//   tx_data_len  payload length in bytes (constant)
//   busy         high from accept until the last byte is served or timeout
//   drop         one-cycle pulse: request rejected or timed out
module face_box_sender #(
    parameter int         BOX_NUM = 2,
    parameter int         H_ACT   = 1280,
    parameter int         V_ACT   = 720,
    parameter logic [7:0] MAGIC   = 8'hA5,
    parameter int         TIMEOUT = 65535
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               send,
    input  logic [BOX_NUM*$clog2(H_ACT)-1:0]   start_xs,
    input  logic [BOX_NUM*$clog2(V_ACT)-1:0]   start_ys,
    input  logic [BOX_NUM*$clog2(H_ACT)-1:0]   end_xs,
    input  logic [BOX_NUM*$clog2(V_ACT)-1:0]   end_ys,
    output logic                               trig,
    input  logic                               tx_read_en,
    output logic [7:0]                         tx_data,
    output logic [15:0]                        tx_data_len,
    output logic                               busy,
    output logic                               drop
);

    localparam int XW       = $clog2(H_ACT);
    localparam int YW       = $clog2(V_ACT);
    localparam int BW       = 2 * XW + 2 * YW;
    localparam int BASE_LEN = 2 + 6 * BOX_NUM;
`ifdef FACE_BOX_SENDER_CHKSUM_EN
    localparam int LEN      = BASE_LEN + 1;
`else
    localparam int LEN      = BASE_LEN;
`endif
    localparam int IW       = $clog2(LEN);
    localparam int SLOTS    = 1 << IW;
    localparam int WW       = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_WAIT,
        S_SEND
    } state_t;

    state_t              state, state_d;
    logic                busy_d, trig_d, drop_d;
    logic [7:0]          tx_data_d;
    logic [IW-1:0]       idx, idx_d;
    logic [WW-1:0]       wcnt, wcnt_d;
    logic [7:0]          seq, seq_d;
    logic                snap_load;

    logic [BOX_NUM*XW-1:0] snap_sx, snap_ex;
    logic [BOX_NUM*YW-1:0] snap_sy, snap_ey;

    logic [7:0]          pay [SLOTS];
    logic [47:0]         word;
`ifdef FACE_BOX_SENDER_CHKSUM_EN
    logic [7:0]          chk;
`endif

    assign tx_data_len = 16'(LEN);

    // Coordinate snapshot. Box inputs are quasi-static and are sampled only
    // at accept, so the packet in flight is immune to later input changes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            snap_sx <= '0;
            snap_sy <= '0;
            snap_ex <= '0;
            snap_ey <= '0;
        end else if (snap_load) begin
            snap_sx <= start_xs;
            snap_sy <= start_ys;
            snap_ex <= end_xs;
            snap_ey <= end_ys;
        end
    end

    // Flat payload image built from the snapshot and the current seq.
    // Unused slots above LEN-1 stay zero, so indexing with idx is always in range.
    always_comb begin
        word = '0;
`ifdef FACE_BOX_SENDER_CHKSUM_EN
        chk  = '0;
`endif
        for (int unsigned s = 0; s < SLOTS; s++) begin
            pay[s] = '0;
        end
        pay[0] = MAGIC;
        pay[1] = seq;
        for (int unsigned b = 0; b < BOX_NUM; b++) begin
            word         = '0;
            word[BW-1:0] = {snap_sx[b*XW +: XW], snap_sy[b*YW +: YW],
                            snap_ex[b*XW +: XW], snap_ey[b*YW +: YW]};
            for (int unsigned k = 0; k < 6; k++) begin
                pay[2 + 6*b + k] = word[47 - 8*k -: 8];
            end
        end
`ifdef FACE_BOX_SENDER_CHKSUM_EN
        for (int unsigned s = 0; s < BASE_LEN; s++) begin
            chk = chk ^ pay[s];
        end
        pay[BASE_LEN] = chk;
`endif
    end

    // All outputs are registered. trig is set on the accept edge, so it is
    // high for exactly the cycle the FSM spends in ARM.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            trig    <= 1'b0;
            drop    <= 1'b0;
            tx_data <= 8'h00;
            idx     <= '0;
            wcnt    <= '0;
            seq     <= 8'h00;
        end else begin
            state   <= state_d;
            busy    <= busy_d;
            trig    <= trig_d;
            drop    <= drop_d;
            tx_data <= tx_data_d;
            idx     <= idx_d;
            wcnt    <= wcnt_d;
            seq     <= seq_d;
        end
    end

    always_comb begin
        state_d   = state;
        busy_d    = busy;
        trig_d    = 1'b0;
        drop_d    = 1'b0;
        tx_data_d = tx_data;
        idx_d     = idx;
        wcnt_d    = wcnt;
        seq_d     = seq;
        snap_load = 1'b0;

        case (state)
            S_IDLE: begin
                if (tx_read_en) begin
                    tx_data_d = 8'h00;
                end
                if (send) begin
                    snap_load = 1'b1;
                    busy_d    = 1'b1;
                    trig_d    = 1'b1;
                    state_d   = S_ARM;
                end
            end

            S_ARM: begin
                if (tx_read_en) begin
                    tx_data_d = 8'h00;
                end
                if (send) begin
                    drop_d = 1'b1;
                end
                idx_d   = '0;
                wcnt_d  = '0;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (send) begin
                    drop_d = 1'b1;
                end
                if (tx_read_en) begin
                    tx_data_d = pay[idx];
                    idx_d     = idx + 1'b1;
                    state_d   = S_SEND;
                end else if (wcnt == WW'(TIMEOUT - 1)) begin
                    // Timed out after TIMEOUT idle WAIT cycles; seq is kept
                    // so the next packet reuses the same sequence number.
                    drop_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    wcnt_d = wcnt + 1'b1;
                end
            end

            S_SEND: begin
                // A send here, including on the last-byte cycle, is rejected.
                if (send) begin
                    drop_d = 1'b1;
                end
                if (tx_read_en) begin
                    tx_data_d = pay[idx];
                    if (idx == IW'(LEN - 1)) begin
                        busy_d  = 1'b0;
                        seq_d   = seq + 8'd1;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx + 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_face_box_sender.sv
module tb_face_box_sender;

`ifdef FACE_BOX_SENDER_CHKSUM_EN
    localparam int LEN = 15;
`else
    localparam int LEN = 14;
`endif

    logic        clk;
    logic        rstn;
    logic        send;
    logic [21:0] start_xs;
    logic [19:0] start_ys;
    logic [21:0] end_xs;
    logic [19:0] end_ys;
    logic        trig;
    logic        tx_read_en;
    logic [7:0]  tx_data;
    logic [15:0] tx_data_len;
    logic        busy;
    logic        drop;

    int n_vec = 0;
    int n_err = 0;

    face_box_sender #(
        .TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .send        (send),
        .start_xs    (start_xs),
        .start_ys    (start_ys),
        .end_xs      (end_xs),
        .end_ys      (end_ys),
        .trig        (trig),
        .tx_read_en  (tx_read_en),
        .tx_data     (tx_data),
        .tx_data_len (tx_data_len),
        .busy        (busy),
        .drop        (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-computed payload for box0=(100,50,300,250), box1=(0,0,1279,719):
    //   box0 word 0x0032_0644_B0FA, box1 word 0x0000_0013_FECF.
    function automatic logic [7:0] exp_byte(input logic [7:0] sq, input int i);
        logic [7:0] t [14];
        logic [7:0] x;
        t = '{8'hA5, sq, 8'h00, 8'h32, 8'h06, 8'h44, 8'hB0, 8'hFA,
              8'h00, 8'h00, 8'h00, 8'h13, 8'hFE, 8'hCF};
        if (i < 14) return t[i];
        x = 8'h00;
        for (int j = 0; j < 14; j++) x = x ^ t[j];
        return x;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_boxes_a;
        start_xs = {11'd0,    11'd100};
        start_ys = {10'd0,    10'd50};
        end_xs   = {11'd1279, 11'd300};
        end_ys   = {10'd719,  10'd250};
    endtask

    task automatic accept_and_arm;
        send = 1'b1;
        tick;
        send = 1'b0;
        check("trig_arm", 16'(trig), 16'd1);
        check("busy_arm", 16'(busy), 16'd1);
        tick;
        check("trig_wait", 16'(trig), 16'd0);
    endtask

    initial begin
        rstn       = 1'b0;
        send       = 1'b0;
        tx_read_en = 1'b0;
        start_xs   = '0;
        start_ys   = '0;
        end_xs     = '0;
        end_ys     = '0;
        tick;
        tick;
        check("rst_trig", 16'(trig), 16'd0);
        check("rst_data", 16'(tx_data), 16'h00);
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_drop", 16'(drop), 16'd0);
        check("len", tx_data_len, 16'(LEN));
        rstn = 1'b1;
        tick;

        // Packet 1: contiguous reads, seq 0.
        set_boxes_a;
        tick;
        check("idle_trig", 16'(trig), 16'd0);
        accept_and_arm;
        for (int i = 0; i < LEN; i++) begin
            tx_read_en = 1'b1;
            tick;
            check($sformatf("p1_b%0d", i), 16'(tx_data), 16'(exp_byte(8'h00, i)));
            check($sformatf("p1_busy%0d", i), 16'(busy), 16'(i < LEN - 1));
        end
        tx_read_en = 1'b0;
        tick;
        check("p1_held", 16'(tx_data), 16'(exp_byte(8'h00, LEN - 1)));
        check("p1_drop", 16'(drop), 16'd0);

        // Read in IDLE returns zero and does not disturb the next packet.
        tx_read_en = 1'b1;
        tick;
        tx_read_en = 1'b0;
        check("idle_read", 16'(tx_data), 16'h00);

        // Packet 2: 3-cycle gaps, inputs changed after accept, seq 1.
        accept_and_arm;
        start_xs = {11'd7, 11'd9};
        start_ys = {10'd3, 10'd5};
        end_xs   = {11'd2, 11'd4};
        end_ys   = {10'd1, 10'd8};
        for (int i = 0; i < LEN; i++) begin
            tx_read_en = 1'b1;
            tick;
            tx_read_en = 1'b0;
            check($sformatf("p2_b%0d", i), 16'(tx_data), 16'(exp_byte(8'h01, i)));
            tick;
            tick;
            tick;
            if (i == 4 || i == LEN - 1)
                check($sformatf("p2_hold%0d", i), 16'(tx_data), 16'(exp_byte(8'h01, i)));
        end
        check("p2_busy", 16'(busy), 16'd0);

        // Packet 3: send during SEND and on the last-byte cycle, seq 2.
        set_boxes_a;
        accept_and_arm;
        for (int i = 0; i < LEN; i++) begin
            tx_read_en = 1'b1;
            send       = (i == 5 || i == LEN - 1);
            tick;
            check($sformatf("p3_b%0d", i), 16'(tx_data), 16'(exp_byte(8'h02, i)));
            check($sformatf("p3_drop%0d", i), 16'(drop), 16'(i == 5 || i == LEN - 1));
        end
        tx_read_en = 1'b0;
        send       = 1'b0;
        check("p3_busy", 16'(busy), 16'd0);
        tick;
        check("p3_drop_end", 16'(drop), 16'd0);
        check("p3_trig_end", 16'(trig), 16'd0);
        check("p3_idle", 16'(busy), 16'd0);

        // Packet 4: no reads after trig -> timeout after 16 WAIT cycles.
        accept_and_arm;
        for (int i = 0; i < 15; i++) tick;
        check("to_drop_early", 16'(drop), 16'd0);
        check("to_busy_early", 16'(busy), 16'd1);
        tick;
        check("to_drop", 16'(drop), 16'd1);
        check("to_busy", 16'(busy), 16'd0);
        tick;
        check("to_drop_clr", 16'(drop), 16'd0);

        // Packet 5: seq still 3; abandon with reset after 5 bytes.
        accept_and_arm;
        for (int i = 0; i < 5; i++) begin
            tx_read_en = 1'b1;
            tick;
            check($sformatf("p5_b%0d", i), 16'(tx_data), 16'(exp_byte(8'h03, i)));
        end
        tx_read_en = 1'b0;
        rstn = 1'b0;
        #1;
        check("ar_busy", 16'(busy), 16'd0);
        check("ar_data", 16'(tx_data), 16'h00);
        check("ar_trig", 16'(trig), 16'd0);
        check("ar_drop", 16'(drop), 16'd0);
        rstn = 1'b1;
        tick;

        // Packet 6: seq back to 0 after reset.
        accept_and_arm;
        for (int i = 0; i < 2; i++) begin
            tx_read_en = 1'b1;
            tick;
            check($sformatf("p6_b%0d", i), 16'(tx_data), 16'(exp_byte(8'h00, i)));
        end
        tx_read_en = 1'b0;
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
